// File: rtl/hazard_ctrl.sv
// Hazard detection for the 5-stage pipeline.
// A three-entry shadow scoreboard tracks the destination registers in flight
// in EX, MEM and WB. The ID instruction is stalled until every producer it
// reads from has retired (there is no forwarding). A redirect resolved in EX
// flushes the front end and takes priority over any stall. Stall and flush
// cycles are counted in free-running wrapping counters.
module hazard_ctrl #(
    parameter int WB_BYPASS = 0,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_re1,
    input  logic             ID_re2,
    input  logic [4:0]       ID_wR,
    input  logic             ID_rf_we,
    input  logic             EX_redirect,
    output logic             data_hazard,
    output logic             control_hazard,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic [4:0] wr;
        logic       we;
    } sb_entry_t;

    sb_entry_t        sb_ex_q, sb_ex_d;
    sb_entry_t        sb_mem_q, sb_mem_d;
    sb_entry_t        sb_wb_q, sb_wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;
    logic raw;

    // An in-flight producer conflicts with one source operand; x0 is never a producer.
    function automatic logic src_match(input sb_entry_t e, input logic [4:0] rs, input logic re);
        return e.we && (e.wr != 5'd0) && (e.wr == rs) && re;
    endfunction

    // An entry conflicts with the ID instruction if it feeds either operand.
    function automatic logic entry_hit(input sb_entry_t e, input logic [4:0] rs1, input logic re1,
                                       input logic [4:0] rs2, input logic re2);
        return src_match(e, rs1, re1) || src_match(e, rs2, re2);
    endfunction

    // Read-after-write detection against the in-flight producers.
    always_comb begin
        hit_ex  = entry_hit(sb_ex_q, ID_rs1, ID_re1, ID_rs2, ID_re2);
        hit_mem = entry_hit(sb_mem_q, ID_rs1, ID_re1, ID_rs2, ID_re2);
        // A write-through register file already delivers the WB value to ID.
        hit_wb  = (WB_BYPASS == 0) ? entry_hit(sb_wb_q, ID_rs1, ID_re1, ID_rs2, ID_re2) : 1'b0;
        raw     = hit_ex | hit_mem | hit_wb;
    end

    // Hazard outputs; a redirect squashes the ID instruction so it never stalls.
    always_comb begin
        data_hazard    = 1'b0;
        control_hazard = 1'b0;
        if (!rst) begin
            control_hazard = EX_redirect;
            data_hazard    = raw & ~EX_redirect;
        end
        pc_stall    = data_hazard;
        if_id_stall = data_hazard;
    end

    // Next scoreboard contents and counter values; bubbles and flushed slots enter with we=0.
    always_comb begin
        sb_wb_d     = sb_mem_q;
        sb_mem_d    = sb_ex_q;
        sb_ex_d.wr  = ID_wR;
        sb_ex_d.we  = ID_rf_we & ~data_hazard & ~control_hazard;
        stall_cnt_d = stall_cnt_q + CNT_W'(data_hazard);
        flush_cnt_d = flush_cnt_q + CNT_W'(control_hazard);
    end

    // Scoreboard shift register and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_ex_q     <= '0;
            sb_mem_q    <= '0;
            sb_wb_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_ex_q     <= sb_ex_d;
            sb_mem_q    <= sb_mem_d;
            sb_wb_q     <= sb_wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances share the stimulus
// (u0: WB checked, 32-bit counters; u1: WB bypassed; u2: WB checked, 4-bit counters).
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_wr = 5'd0;
    logic       id_re1 = 1'b0, id_re2 = 1'b0, id_rf_we = 1'b0, ex_redirect = 1'b1;

    logic        dh [3];
    logic        ch [3];
    logic        ps [3];
    logic        ifs [3];
    logic [31:0] sc0, fc0, sc1, fc1;
    logic [3:0]  sc2, fc2;
    logic [31:0] sc_act [3];
    logic [31:0] fc_act [3];

    assign sc_act[0] = sc0;
    assign sc_act[1] = sc1;
    assign sc_act[2] = {28'd0, sc2};
    assign fc_act[0] = fc0;
    assign fc_act[1] = fc1;
    assign fc_act[2] = {28'd0, fc2};

    hazard_ctrl #(.WB_BYPASS(0), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst), .ID_rs1(id_rs1), .ID_rs2(id_rs2), .ID_re1(id_re1), .ID_re2(id_re2),
        .ID_wR(id_wr), .ID_rf_we(id_rf_we), .EX_redirect(ex_redirect),
        .data_hazard(dh[0]), .control_hazard(ch[0]), .pc_stall(ps[0]), .if_id_stall(ifs[0]),
        .stall_cnt(sc0), .flush_cnt(fc0));

    hazard_ctrl #(.WB_BYPASS(1), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .ID_rs1(id_rs1), .ID_rs2(id_rs2), .ID_re1(id_re1), .ID_re2(id_re2),
        .ID_wR(id_wr), .ID_rf_we(id_rf_we), .EX_redirect(ex_redirect),
        .data_hazard(dh[1]), .control_hazard(ch[1]), .pc_stall(ps[1]), .if_id_stall(ifs[1]),
        .stall_cnt(sc1), .flush_cnt(fc1));

    hazard_ctrl #(.WB_BYPASS(0), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .ID_rs1(id_rs1), .ID_rs2(id_rs2), .ID_re1(id_re1), .ID_re2(id_re2),
        .ID_wR(id_wr), .ID_rf_we(id_rf_we), .EX_redirect(ex_redirect),
        .data_hazard(dh[2]), .control_hazard(ch[2]), .pc_stall(ps[2]), .if_id_stall(ifs[2]),
        .stall_cnt(sc2), .flush_cnt(fc2));

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: list of the last instructions that left ID, youngest first.
    // A reader must wait while any of the last `depth` issued writers targets one of its sources.
    int          depth [3] = '{3, 2, 3};
    logic [31:0] cmask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};
    logic [4:0]  m_wr [3][3];
    logic        m_we [3][3];
    logic [31:0] m_sc [3];
    logic [31:0] m_fc [3];

    function automatic logic m_raw(input int v);
        for (int i = 0; i < depth[v]; i++) begin
            if (m_we[v][i] && m_wr[v][i] != 5'd0 &&
                ((id_re1 && m_wr[v][i] == id_rs1) || (id_re2 && m_wr[v][i] == id_rs2)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic m_dh(input int v);
        return !rst && !ex_redirect && m_raw(v);
    endfunction

    function automatic logic m_ch();
        return !rst && ex_redirect;
    endfunction

    always @(posedge clk) begin
        for (int v = 0; v < 3; v++) begin
            if (rst) begin
                for (int i = 0; i < 3; i++) begin
                    m_wr[v][i] <= 5'd0;
                    m_we[v][i] <= 1'b0;
                end
                m_sc[v] <= 32'd0;
                m_fc[v] <= 32'd0;
            end else begin
                m_sc[v]    <= (m_sc[v] + {31'd0, m_dh(v)}) & cmask[v];
                m_fc[v]    <= (m_fc[v] + {31'd0, ex_redirect}) & cmask[v];
                m_wr[v][2] <= m_wr[v][1];
                m_we[v][2] <= m_we[v][1];
                m_wr[v][1] <= m_wr[v][0];
                m_we[v][1] <= m_we[v][0];
                m_wr[v][0] <= id_wr;
                m_we[v][0] <= id_rf_we & ~m_dh(v) & ~ex_redirect;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int v = 0; v < 3; v++) begin
                check($sformatf("u%0d.data_hazard", v), {31'd0, dh[v]}, {31'd0, m_dh(v)});
                check($sformatf("u%0d.control_hazard", v), {31'd0, ch[v]}, {31'd0, m_ch()});
                check($sformatf("u%0d.pc_stall", v), {31'd0, ps[v]}, {31'd0, m_dh(v)});
                check($sformatf("u%0d.if_id_stall", v), {31'd0, ifs[v]}, {31'd0, m_dh(v)});
                check($sformatf("u%0d.stall_cnt", v), sc_act[v], m_sc[v]);
                check($sformatf("u%0d.flush_cnt", v), fc_act[v], m_fc[v]);
            end
        end
    end

    task automatic issue(input logic [4:0] rs1, input logic re1, input logic [4:0] rs2,
                         input logic re2, input logic [4:0] wr, input logic we, input logic redir);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        id_rs1      = rs1;
        id_re1      = re1;
        id_rs2      = rs2;
        id_re2      = re2;
        id_wr       = wr;
        id_rf_we    = we;
        ex_redirect = redir;
    endtask

    task automatic idle();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n, input logic redir);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst         = 1'b1;
            ex_redirect = redir;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset held with a pending redirect: every hazard output stays low.
        do_reset(2, 1'b1);
        @(negedge clk);
        check("rst_dh", {31'd0, dh[0]}, 32'd0);
        check("rst_ch", {31'd0, ch[0]}, 32'd0);
        check("rst_ps", {31'd0, ps[0]}, 32'd0);
        check("rst_ifs", {31'd0, ifs[0]}, 32'd0);
        idle();
        @(negedge clk);
        check("rst_sc", sc0, 32'd0);
        check("rst_fc", fc0, 32'd0);

        // Back-to-back RAW on x5: 3 stall cycles with WB checked, 2 with WB bypassed.
        do_reset(1, 1'b0);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            @(negedge clk);
            check($sformatf("raw_u0_c%0d", c), {31'd0, dh[0]}, (c <= 3) ? 32'd1 : 32'd0);
            check($sformatf("raw_u1_c%0d", c), {31'd0, dh[1]}, (c <= 2) ? 32'd1 : 32'd0);
        end
        idle();
        @(negedge clk);
        check("raw_sc_u0", sc0, 32'd3);
        check("raw_sc_u1", sc1, 32'd2);

        // x0 is never a producer; a disabled read port never matches; rs2 does match when enabled.
        do_reset(1, 1'b0);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("x0_no_stall", {31'd0, dh[0]}, 32'd0);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        issue(5'd0, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("re2_off_no_stall", {31'd0, dh[0]}, 32'd0);
        issue(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("rs2_stall", {31'd0, dh[0]}, 32'd1);

        // Both sources on the same producer: one stall count per cycle.
        do_reset(1, 1'b0);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) issue(5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        check("dual_src_sc", sc0, 32'd3);

        // Redirect on the second stall cycle wins over the stall.
        do_reset(1, 1'b0);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("redir_stall1", {31'd0, dh[0]}, 32'd1);
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        @(negedge clk);
        check("redir_dh", {31'd0, dh[0]}, 32'd0);
        check("redir_ch", {31'd0, ch[0]}, 32'd1);
        check("redir_ps", {31'd0, ps[0]}, 32'd0);
        issue(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("redir_next_dh", {31'd0, dh[0]}, 32'd0);
        check("redir_next_ch", {31'd0, ch[0]}, 32'd0);
        check("redir_fc", fc0, 32'd1);
        check("redir_sc", sc0, 32'd1);

        // Reset in the middle of a stall empties the scoreboard.
        do_reset(1, 1'b0);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("mid_rst_stall", {31'd0, dh[0]}, 32'd1);
        do_reset(1, 1'b0);
        @(negedge clk);
        check("mid_rst_forced", {31'd0, dh[0]}, 32'd0);
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("mid_rst_after", {31'd0, dh[0]}, 32'd0);

        // 17 stall cycles on the WB-checked instances; the 4-bit counter wraps to 1.
        do_reset(1, 1'b0);
        for (int r = 0; r < 5; r++) begin
            issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
            for (int c = 0; c < 4; c++) issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        end
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        idle();
        for (int c = 0; c < 3; c++) issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        check("wrap_sc_u0", sc0, 32'd17);
        check("wrap_sc_u1", sc1, 32'd11);
        check("wrap_sc_u2", {28'd0, sc2}, 32'd1);

        idle();
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
